// File: rtl/rsvs_issue_sched_pkg.sv
// Shared sizing and bit-vector helpers for the reservation-station issue scheduler.
package rsvs_issue_sched_pkg;

  localparam int unsigned DEPTH_DEF = 8;
  localparam int unsigned MAX_DEPTH = 64;
  localparam int unsigned MAX_IDXW  = 6;

  typedef logic [MAX_DEPTH-1:0] wide_mask_t;
  typedef logic [MAX_IDXW-1:0]  wide_idx_t;

  function automatic int unsigned idx_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Isolates the lowest set bit; turns a candidate mask into a strict one-hot.
  function automatic wide_mask_t lowest_set(input wide_mask_t v);
    return v & (~v + wide_mask_t'(1));
  endfunction

  function automatic wide_idx_t onehot_to_idx(input wide_mask_t v);
    wide_idx_t idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
      if (v[i]) idx = idx | wide_idx_t'(i);
    end
    return idx;
  endfunction

  function automatic wide_mask_t idx_to_onehot(input wide_idx_t idx);
    return wide_mask_t'(1) << idx;
  endfunction

endpackage

// File: rtl/rsvs_issue_sched_age_matrix.sv
// Age matrix of RS entries: records allocation order and picks the oldest eligible entry.
module rsvs_issue_sched_age_matrix
  import rsvs_issue_sched_pkg::*;
#(
  parameter  int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned IDXW  = idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_alloc_valid,
  input  logic [IDXW-1:0]  i_alloc_idx,
  input  logic [DEPTH-1:0] i_elig,
  output logic [DEPTH-1:0] o_win,
  output logic             o_has_win
);

  // r_older[i][j] = 1 : entry i was allocated before entry j
  logic [DEPTH-1:0] r_older [DEPTH];
  logic [DEPTH-1:0] w_col   [DEPTH];
  logic [DEPTH-1:0] w_cand;

  // NOTE: the matrix is reset even though it is memory-like, because selection reads
  // every bit combinationally from the first cycle; X here would propagate into o_win.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_older[i] <= '0;
    end else if (i_alloc_valid) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        // NOTE: non-blocking so every row update sees the pre-edge matrix.
        if (IDXW'(i) == i_alloc_idx) r_older[i] <= '0;
        else                         r_older[i][i_alloc_idx] <= 1'b1;
      end
    end
  end

  for (genvar w = 0; w < DEPTH; w++) begin : g_sel
    for (genvar j = 0; j < DEPTH; j++) begin : g_col
      assign w_col[w][j] = r_older[j][w];
    end
    // w is a candidate when no other eligible entry is older than it
    assign w_cand[w] = i_elig[w] & ~|(i_elig & w_col[w]);
  end

  assign o_win     = DEPTH'(lowest_set(wide_mask_t'(w_cand)));
  assign o_has_win = |i_elig;

endmodule

// File: rtl/rsvs_issue_sched.sv
// Oldest-ready issue scheduler for one reservation station with a registered FU issue stage.
module rsvs_issue_sched
  import rsvs_issue_sched_pkg::*;
#(
  parameter  int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned IDXW  = idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_alloc_valid,
  input  logic [IDXW-1:0]  i_alloc_idx,
  input  logic [DEPTH-1:0] i_entry_valid,
  input  logic [DEPTH-1:0] i_entry_ready,
  output logic             o_issue_valid,
  output logic [IDXW-1:0]  o_issue_idx,
  input  logic             i_issue_ready,
  output logic [DEPTH-1:0] o_grant_clear
);

  logic             r_issue_valid;
  logic [IDXW-1:0]  r_issue_idx;
  logic [DEPTH-1:0] w_elig;
  logic [DEPTH-1:0] w_win;
  logic             w_has_win;
  logic [IDXW-1:0]  w_win_idx;
  logic             w_load;
  logic             w_handshake;

  // Held entry and entries being allocated this cycle are not candidates.
  for (genvar i = 0; i < DEPTH; i++) begin : g_elig
    assign w_elig[i] = i_entry_valid[i] & i_entry_ready[i]
                     & ~(r_issue_valid & (r_issue_idx == IDXW'(i)))
                     & ~(i_alloc_valid & (i_alloc_idx == IDXW'(i)));
  end

  rsvs_issue_sched_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk           (clk),
    .rst           (rst),
    .i_alloc_valid (i_alloc_valid),
    .i_alloc_idx   (i_alloc_idx),
    .i_elig        (w_elig),
    .o_win         (w_win),
    .o_has_win     (w_has_win)
  );

  assign w_win_idx   = IDXW'(onehot_to_idx(wide_mask_t'(w_win)));
  assign w_load      = ~r_issue_valid | i_issue_ready;
  assign w_handshake = r_issue_valid & i_issue_ready & ~i_flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_issue_valid <= 1'b0;
      r_issue_idx   <= '0;
    end else if (i_flush) begin
      r_issue_valid <= 1'b0;
    end else if (w_load) begin
      r_issue_valid <= w_has_win;
      if (w_has_win) r_issue_idx <= w_win_idx;
    end
  end

  assign o_issue_valid = r_issue_valid;
  assign o_issue_idx   = r_issue_idx;
  assign o_grant_clear = w_handshake ? DEPTH'(idx_to_onehot(wide_idx_t'(r_issue_idx))) : '0;

  // RS must not reuse an entry that is still held by the issue stage.
  a_alloc_vs_grant: assert property (@(posedge clk) disable iff (!rst)
    (i_alloc_valid && w_handshake) |-> (i_alloc_idx != r_issue_idx));
  a_alloc_vs_held: assert property (@(posedge clk) disable iff (!rst)
    (i_alloc_valid && r_issue_valid) |-> (i_alloc_idx != r_issue_idx));
  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst)
    $onehot0(o_grant_clear));

endmodule

// File: tb/tb_rsvs_issue_sched.sv
// Directed scoreboard bench for rsvs_issue_sched: expected issue order is queued by the
// stimulus and popped by a negedge monitor on every FU handshake.
module tb_rsvs_issue_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       alloc_valid;
  logic [2:0] alloc_idx;
  logic [7:0] ev;
  logic [7:0] er;
  logic       ir;
  logic       issue_valid;
  logic [2:0] issue_idx;
  logic [7:0] gc;

  int unsigned exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  rsvs_issue_sched #(.DEPTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_flush       (flush),
    .i_alloc_valid (alloc_valid),
    .i_alloc_idx   (alloc_idx),
    .i_entry_valid (ev),
    .i_entry_ready (er),
    .o_issue_valid (issue_valid),
    .o_issue_idx   (issue_idx),
    .i_issue_ready (ir),
    .o_grant_clear (gc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // One cycle of the RS model: entries granted in this cycle are freed after the edge.
  task automatic tick();
    logic [7:0] gc_q;
    @(negedge clk);
    gc_q = gc;
    @(posedge clk);
    #1;
    ev = ev & ~gc_q;
    er = er & ~gc_q;
  endtask

  task automatic do_alloc(input logic [2:0] k, input logic rdy);
    alloc_valid = 1'b1;
    alloc_idx   = k;
    ev[k]       = 1'b1;
    er[k]       = rdy;
  endtask

  // Monitor: every handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && issue_valid && ir && !flush) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_issue: got idx %0d expected no issue at %0t", issue_idx, $time);
      end else begin
        int unsigned e;
        e = exp_q.pop_front();
        check("issue_idx", 32'(issue_idx), e);
        check("grant_clear", 32'(gc), 32'(1) << e);
      end
    end else begin
      check("grant_idle", 32'(gc), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset with random inputs
    rst         = 1'b0;
    flush       = 1'($urandom_range(1));
    alloc_valid = 1'($urandom_range(1));
    alloc_idx   = 3'($urandom_range(7));
    ev          = 8'($urandom);
    er          = 8'($urandom);
    ir          = 1'($urandom_range(1));
    #23;
    check("rst_valid", 32'(issue_valid), 32'd0);
    check("rst_idx", 32'(issue_idx), 32'd0);
    check("rst_gc", 32'(gc), 32'd0);
    flush = 1'b0; alloc_valid = 1'b0; alloc_idx = '0; ev = '0; er = '0; ir = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // 2: age order 3,5,1 with all three becoming ready together
    tick(); do_alloc(3'd3, 1'b0);
    tick(); do_alloc(3'd5, 1'b0);
    tick(); do_alloc(3'd1, 1'b0);
    tick(); alloc_valid = 1'b0;
    er = 8'b0010_1010; ir = 1'b1;
    exp_q.push_back(3); exp_q.push_back(5); exp_q.push_back(1);
    check("age_pre_valid", 32'(issue_valid), 32'd0);
    tick(); check("age_v0", 32'(issue_valid), 32'd1); check("age_i0", 32'(issue_idx), 32'd3);
    tick(); check("age_v1", 32'(issue_valid), 32'd1); check("age_i1", 32'(issue_idx), 32'd5);
    tick(); check("age_v2", 32'(issue_valid), 32'd1); check("age_i2", 32'(issue_idx), 32'd1);
    tick(); check("age_drain", 32'(issue_valid), 32'd0);

    // 3: stall with entry 3 held while a younger entry 6 becomes ready
    ir = 1'b0;
    do_alloc(3'd3, 1'b1);
    tick(); alloc_valid = 1'b0;
    check("stall_alloc_not_elig", 32'(issue_valid), 32'd0);
    tick(); check("stall_load_v", 32'(issue_valid), 32'd1); check("stall_load_i", 32'(issue_idx), 32'd3);
    do_alloc(3'd6, 1'b1);
    for (int c = 0; c < 4; c++) begin
      tick(); alloc_valid = 1'b0;
      check("stall_v", 32'(issue_valid), 32'd1);
      check("stall_i", 32'(issue_idx), 32'd3);
    end
    exp_q.push_back(3); exp_q.push_back(6);
    ir = 1'b1;
    tick(); check("stall_next_v", 32'(issue_valid), 32'd1); check("stall_next_i", 32'(issue_idx), 32'd6);
    tick(); check("stall_drain", 32'(issue_valid), 32'd0);

    // 4: younger entry ready first issues first
    do_alloc(3'd0, 1'b0);
    tick(); do_alloc(3'd7, 1'b0);
    tick(); alloc_valid = 1'b0; er[7] = 1'b1;
    exp_q.push_back(7);
    tick(); check("ooo_v7", 32'(issue_valid), 32'd1); check("ooo_i7", 32'(issue_idx), 32'd7);
    er[0] = 1'b1;
    exp_q.push_back(0);
    tick(); check("ooo_v0", 32'(issue_valid), 32'd1); check("ooo_i0", 32'(issue_idx), 32'd0);
    tick(); check("ooo_drain", 32'(issue_valid), 32'd0);

    // 5: flush while the FU is accepting
    ir = 1'b0;
    do_alloc(3'd2, 1'b1);
    tick(); alloc_valid = 1'b0;
    tick(); check("flush_pre_v", 32'(issue_valid), 32'd1); check("flush_pre_i", 32'(issue_idx), 32'd2);
    flush = 1'b1; ir = 1'b1;
    #1; check("flush_gc", 32'(gc), 32'd0);
    tick(); flush = 1'b0; ev[2] = 1'b0; er[2] = 1'b0;
    check("flush_v", 32'(issue_valid), 32'd0);
    tick(); check("flush_v_after", 32'(issue_valid), 32'd0);

    // 6: allocated and ready in the same cycle N -> visible at N+2
    do_alloc(3'd4, 1'b1);
    tick(); alloc_valid = 1'b0;
    check("same_cyc_n1", 32'(issue_valid), 32'd0);
    exp_q.push_back(4);
    tick(); check("same_cyc_v", 32'(issue_valid), 32'd1); check("same_cyc_i", 32'(issue_idx), 32'd4);
    tick(); check("same_cyc_drain", 32'(issue_valid), 32'd0);

    // 7: asynchronous reset while stalled
    ir = 1'b0;
    do_alloc(3'd5, 1'b1);
    tick(); alloc_valid = 1'b0;
    tick(); check("mid_rst_pre_v", 32'(issue_valid), 32'd1); check("mid_rst_pre_i", 32'(issue_idx), 32'd5);
    #2; rst = 1'b0; ir = 1'b1;
    #1;
    check("mid_rst_v", 32'(issue_valid), 32'd0);
    check("mid_rst_i", 32'(issue_idx), 32'd0);
    check("mid_rst_gc", 32'(gc), 32'd0);
    ev = '0; er = '0; ir = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    tick(); tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
